// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and types for the 1-to-4 stream distributor.
//   N_OUT          number of output slots
//   SEL_W          width of the route selector
//   demux_state_t  route-lock state (IDLE: selector drives the route,
//                  LOCKED: route held until the last beat of a burst)
package demux_pkg;

  localparam int N_OUT = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } demux_state_t;

endpackage

// File: rtl/demux_4_stream_if.sv
// demux_4_stream_if: handshake bundle of the 1-to-4 stream distributor.
//   in_valid/in_ready/in_data/in_last/selector  producer side
//   out_validN/out_readyN/out_dataN/out_lastN   consumer N side (N=0..3)
//   busy                                        route lock active
// Modports: master = producer/consumer environment, slave = distributor.
interface demux_4_stream_if
  import demux_pkg::*;
#(
  parameter int bus = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [bus-1:0]   in_data;
  logic             in_last;
  logic [SEL_W-1:0] selector;

  logic             out_valid0, out_valid1, out_valid2, out_valid3;
  logic             out_ready0, out_ready1, out_ready2, out_ready3;
  logic [bus-1:0]   out_data0, out_data1, out_data2, out_data3;
  logic             out_last0, out_last1, out_last2, out_last3;

  logic             busy;

  modport master (
    output in_valid, in_data, in_last, selector,
    output out_ready0, out_ready1, out_ready2, out_ready3,
    input  in_ready, busy,
    input  out_valid0, out_valid1, out_valid2, out_valid3,
    input  out_data0, out_data1, out_data2, out_data3,
    input  out_last0, out_last1, out_last2, out_last3
  );

  modport slave (
    input  in_valid, in_data, in_last, selector,
    input  out_ready0, out_ready1, out_ready2, out_ready3,
    output in_ready, busy,
    output out_valid0, out_valid1, out_valid2, out_valid3,
    output out_data0, out_data1, out_data2, out_data3,
    output out_last0, out_last1, out_last2, out_last3
  );

endinterface

// File: rtl/demux_out_slot.sv
// demux_out_slot: one-entry registered output slot with valid/ready handshake.
//   clk, rst            clock, synchronous active-high reset
//   wr_en/wr_data/wr_last  load a beat (caller guarantees the slot is free
//                          or draining this cycle)
//   rd_ready            consumer takes the beat when valid & rd_ready
//   valid/data/last     slot contents
// A write in the same cycle as a read refills the slot, giving one beat/cycle.
module demux_out_slot #(
  parameter int bus = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [bus-1:0] wr_data,
  input  logic           wr_last,
  input  logic           rd_ready,
  output logic           valid,
  output logic [bus-1:0] data,
  output logic           last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (wr_en) begin
      valid <= 1'b1;
      data  <= wr_data;
      last  <= wr_last;
    end else if (rd_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_4_stream.sv
// demux_4_stream: 1-to-4 stream distributor with burst route locking.
//   clk, rst   single clock, synchronous active-high reset
//   stream     demux_4_stream_if.slave: input beat, selector, four output
//              slots, busy (1 while a burst holds the route)
//   cnt_o      per-output delivered-beat counters, CNT_W bits each
//              (only when DEMUX_STATS_EN is defined)
// Optional feature macro: DEMUX_STATS_EN.
module demux_4_stream
  import demux_pkg::*;
#(
  parameter int bus   = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  demux_4_stream_if.slave        stream
`ifdef DEMUX_STATS_EN
  ,
  output logic [N_OUT*CNT_W-1:0] cnt_o
`endif
);

  demux_state_t     state;
  logic [SEL_W-1:0] route;
  logic [SEL_W-1:0] sel_eff;
  logic             in_ready;
  logic             accept;
  logic [N_OUT-1:0] wr_en;
  logic [N_OUT-1:0] slot_valid;
  logic [N_OUT-1:0] slot_ready;
  logic [N_OUT-1:0] slot_last;
  logic [bus-1:0]   slot_data [N_OUT];

  assign slot_ready = {stream.out_ready3, stream.out_ready2,
                       stream.out_ready1, stream.out_ready0};

  // Route select and write decode: a slot accepts when empty or draining now.
  assign sel_eff  = (state == LOCKED) ? route : stream.selector;
  assign in_ready = ~slot_valid[sel_eff] | slot_ready[sel_eff];
  assign accept   = stream.in_valid & in_ready;

  always_comb begin
    wr_en = '0;
    if (accept) wr_en[sel_eff] = 1'b1;
  end

  // Output slots
  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    demux_out_slot #(.bus(bus)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[i]),
      .wr_data  (stream.in_data),
      .wr_last  (stream.in_last),
      .rd_ready (slot_ready[i]),
      .valid    (slot_valid[i]),
      .data     (slot_data[i]),
      .last     (slot_last[i])
    );
  end

  // Route lock FSM; busy is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      route       <= '0;
      stream.busy <= 1'b0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (!stream.in_last) begin
            state       <= LOCKED;
            route       <= stream.selector;
            stream.busy <= 1'b1;
          end
        end
        LOCKED: begin
          if (stream.in_last) begin
            state       <= IDLE;
            stream.busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stream.in_ready   = in_ready;
  assign stream.out_valid0 = slot_valid[0];
  assign stream.out_valid1 = slot_valid[1];
  assign stream.out_valid2 = slot_valid[2];
  assign stream.out_valid3 = slot_valid[3];
  assign stream.out_data0  = slot_data[0];
  assign stream.out_data1  = slot_data[1];
  assign stream.out_data2  = slot_data[2];
  assign stream.out_data3  = slot_data[3];
  assign stream.out_last0  = slot_last[0];
  assign stream.out_last1  = slot_last[1];
  assign stream.out_last2  = slot_last[2];
  assign stream.out_last3  = slot_last[3];

`ifdef DEMUX_STATS_EN
  // Delivered-beat counters, wrapping modulo 2^CNT_W.
  logic [CNT_W-1:0] cnt [N_OUT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++)
        if (slot_valid[i] && slot_ready[i]) cnt[i] <= cnt[i] + 1'b1;
    end
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_cnt
    assign cnt_o[i*CNT_W +: CNT_W] = cnt[i];
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_demux_4_stream.sv
// tb_demux_4_stream: table-driven vectors plus hand-written corner sequences,
// with a per-port scoreboard of expected beats and an independent route model.
// Build with DEMUX_STATS_EN defined to also check the delivered-beat counters.
module tb_demux_4_stream;
  import demux_pkg::*;

  localparam int BUS   = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_4_stream_if #(.bus(BUS)) dif ();

`ifdef DEMUX_STATS_EN
  logic [N_OUT*CNT_W-1:0] cnt_o;
`endif

  demux_4_stream #(.bus(BUS), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .stream (dif.slave)
`ifdef DEMUX_STATS_EN
    ,
    .cnt_o  (cnt_o)
`endif
  );

  logic [3:0]     rdy;
  logic [3:0]     ov, ol;
  logic [BUS-1:0] od [4];

  assign dif.out_ready0 = rdy[0];
  assign dif.out_ready1 = rdy[1];
  assign dif.out_ready2 = rdy[2];
  assign dif.out_ready3 = rdy[3];
  assign ov = {dif.out_valid3, dif.out_valid2, dif.out_valid1, dif.out_valid0};
  assign ol = {dif.out_last3, dif.out_last2, dif.out_last1, dif.out_last0};
  assign od[0] = dif.out_data0;
  assign od[1] = dif.out_data1;
  assign od[2] = dif.out_data2;
  assign od[3] = dif.out_data3;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: expected beats per port, plus independent route-lock model.
  typedef struct packed {
    logic [BUS-1:0] d;
    logic           l;
  } beat_t;

  beat_t      sb [4][$];
  logic       m_locked = 1'b0;
  logic [1:0] m_route  = 2'd0;
  int         deliv [4];

  always @(negedge clk) begin
    logic [1:0] msel;
    beat_t      b;
    if (rst) begin
      for (int p = 0; p < 4; p++) begin
        sb[p].delete();
        deliv[p] = 0;
      end
      m_locked = 1'b0;
      m_route  = 2'd0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("sb_valid%0d", p), 32'(ov[p]), 32'(sb[p].size() != 0));
        if (ov[p] && sb[p].size() != 0) begin
          chk($sformatf("sb_data%0d", p), 32'(od[p]), 32'(sb[p][0].d));
          chk($sformatf("sb_last%0d", p), 32'(ol[p]), 32'(sb[p][0].l));
        end
      end
      chk("sb_busy", 32'(dif.busy), 32'(m_locked));
      msel = m_locked ? m_route : dif.selector;
      chk("sb_in_ready", 32'(dif.in_ready), 32'((sb[msel].size() == 0) || rdy[msel]));
      for (int p = 0; p < 4; p++) begin
        if (ov[p] && rdy[p] && sb[p].size() != 0) begin
          void'(sb[p].pop_front());
          deliv[p]++;
        end
      end
      if (dif.in_valid && dif.in_ready) begin
        b.d = dif.in_data;
        b.l = dif.in_last;
        sb[msel].push_back(b);
        if (!m_locked && !dif.in_last) begin
          m_locked = 1'b1;
          m_route  = dif.selector;
        end else if (m_locked && dif.in_last) begin
          m_locked = 1'b0;
        end
      end
    end
  end

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send(input logic [1:0] sel, input logic [3:0] d, input logic l,
                      output int waited);
    logic ok;
    @(posedge clk); #1;
    dif.in_valid = 1'b1;
    dif.selector = sel;
    dif.in_data  = d;
    dif.in_last  = l;
    waited = 0;
    forever begin
      @(negedge clk);
      ok = dif.in_ready;
      @(posedge clk); #1;
      if (ok) break;
      waited++;
      if (waited > 50) begin
        chk("send_timeout", 32'(waited), 32'd0);
        break;
      end
    end
    dif.in_valid = 1'b0;
    dif.selector = $urandom_range(0, 3);
  endtask

  // Next negedge: exactly port p valid, holding data d.
  task automatic chk_port(input string nm, input int p, input logic [3:0] d);
    @(negedge clk);
    chk({nm, "_valids"}, 32'(ov), 32'(4'b1 << p));
    chk({nm, "_data"}, 32'(od[p]), 32'(d));
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [3:0] data;
    logic       last;
    logic [3:0] rdy;
    int         exp_port;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int w;

    vecs[0] = '{2'd2, 4'hA, 1'b1, 4'b0100, 2, 1'b0};
    vecs[1] = '{2'd0, 4'h5, 1'b1, 4'b1111, 0, 1'b0};
    vecs[2] = '{2'd1, 4'hC, 1'b1, 4'b1111, 1, 1'b0};
    vecs[3] = '{2'd3, 4'hF, 1'b1, 4'b1111, 3, 1'b0};
    vecs[4] = '{2'd2, 4'h0, 1'b1, 4'b1111, 2, 1'b0};
    vecs[5] = '{2'd0, 4'h3, 1'b0, 4'b1111, 0, 1'b1};
    vecs[6] = '{2'd1, 4'h7, 1'b0, 4'b1111, 0, 1'b1};
    vecs[7] = '{2'd3, 4'h9, 1'b1, 4'b1111, 0, 1'b0};

    dif.in_valid = 1'b0;
    dif.in_data  = '0;
    dif.in_last  = 1'b0;
    dif.selector = 2'd0;
    rdy = 4'b0000;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valids", 32'(ov), 32'd0);
    chk("rst_busy", 32'(dif.busy), 32'd0);
    chk("rst_in_ready", 32'(dif.in_ready), 32'd1);
`ifdef DEMUX_STATS_EN
    chk("rst_cnt", 32'(cnt_o == '0), 32'd1);
`endif

    // Table-driven single beats and a locked burst
    for (int i = 0; i < 8; i++) begin
      rdy = vecs[i].rdy;
      send(vecs[i].sel, vecs[i].data, vecs[i].last, w);
      chk($sformatf("vec%0d_busy", i), 32'(dif.busy), 32'(vecs[i].exp_busy));
      chk_port($sformatf("vec%0d", i), vecs[i].exp_port, vecs[i].data);
    end

    // Burst on port 1, selector moved to 3 mid-burst
    rdy = 4'b1111;
    send(2'd1, 4'h1, 1'b0, w);
    chk("burst_busy1", 32'(dif.busy), 32'd1);
    chk_port("burst_b1", 1, 4'h1);
    send(2'd3, 4'h2, 1'b0, w);
    chk("burst_busy2", 32'(dif.busy), 32'd1);
    chk_port("burst_b2", 1, 4'h2);
    send(2'd3, 4'h3, 1'b1, w);
    chk("burst_busy3", 32'(dif.busy), 32'd0);
    chk_port("burst_b3", 1, 4'h3);

    // Port 0 stalled full; other port still flows; second port-0 beat stalls
    repeat (2) @(posedge clk);
    #1 rdy = 4'b0000;
    send(2'd0, 4'h6, 1'b1, w);
    chk_port("stall_first", 0, 4'h6);
    rdy[3] = 1'b1;
    send(2'd3, 4'h8, 1'b1, w);
    chk("bypass_wait", 32'(w), 32'd0);
    @(negedge clk);
    chk("bypass_valid3", 32'(ov[3]), 32'd1);
    chk("bypass_data3", 32'(od[3]), 32'h8);
    chk("bypass_data0", 32'(od[0]), 32'h6);
    @(posedge clk); #1;
    dif.in_valid = 1'b1;
    dif.selector = 2'd0;
    dif.in_data  = 4'hB;
    dif.in_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(dif.in_ready), 32'd0);
      chk("stall_hold0", 32'(od[0]), 32'h6);
    end
    @(posedge clk); #1 rdy[0] = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(dif.in_ready), 32'd1);
    @(posedge clk); #1 dif.in_valid = 1'b0;
    @(negedge clk);
    chk("release_valid0", 32'(ov[0]), 32'd1);
    chk("release_data0", 32'(od[0]), 32'hB);

    // Reset mid-burst with full slots
    repeat (2) @(posedge clk);
    #1 rdy = 4'b0000;
    send(2'd0, 4'h1, 1'b1, w);
    send(2'd2, 4'h4, 1'b0, w);
    chk("pre_rst_busy", 32'(dif.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valids", 32'(ov), 32'd0);
    chk("mid_rst_busy", 32'(dif.busy), 32'd0);
    rdy = 4'b1000;
    send(2'd3, 4'h5, 1'b1, w);
    chk_port("post_rst", 3, 4'h5);

    // Five beats to port 1
    rdy = 4'b1111;
    for (int k = 0; k < 5; k++) send(2'd1, 4'(k + 1), 1'b1, w);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("deliv1", 32'(deliv[1]), 32'd5);
`ifdef DEMUX_STATS_EN
    chk("cnt1", 32'(cnt_o[1*CNT_W +: CNT_W]), 32'd5);
    chk("cnt3", 32'(cnt_o[3*CNT_W +: CNT_W]), 32'd1);
`endif

    // Nothing left undelivered
    for (int p = 0; p < 4; p++)
      chk($sformatf("drain%0d", p), 32'(sb[p].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
